// File: rtl/reservation_station_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station_pkg
// Description : Shared entry-state encoding and width helper for the
//               reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
package reservation_station_pkg;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_WAITING   = 2'd1,
        ST_READY     = 2'd2,
        ST_EXECUTING = 2'd3
    } entry_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : reservation_station_pkg
`default_nettype wire

// File: rtl/reservation_station_if.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station_if
// Description : Issue, dispatch and CDB signals of the reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
interface reservation_station_if #(
    parameter int DATA_WIDTH    = 4,
    parameter int CDB_TAG_WIDTH = 4,
    parameter int OP_WIDTH      = 2
) ();
    localparam int W = reservation_station_pkg::max_int(DATA_WIDTH, CDB_TAG_WIDTH);

    logic                     cdb_in_valid;
    logic [CDB_TAG_WIDTH-1:0] cdb_in_tag;
    logic [DATA_WIDTH-1:0]    cdb_in_data;

    logic                     issue_valid;
    logic                     issue_ready;
    logic [OP_WIDTH-1:0]      issue_op;
    logic [W-1:0]             issue_src1_data;
    logic [W-1:0]             issue_src2_data;
    logic                     issue_src1_valid;
    logic                     issue_src2_valid;
    logic [CDB_TAG_WIDTH-1:0] issue_tag;

    logic                     dispatch_valid;
    logic                     dispatch_ready;
    logic [OP_WIDTH-1:0]      dispatch_op;
    logic [DATA_WIDTH-1:0]    dispatch_src1;
    logic [DATA_WIDTH-1:0]    dispatch_src2;
    logic [CDB_TAG_WIDTH-1:0] dispatch_tag;

    // Reservation-station side.
    modport slave (
        input  cdb_in_valid, cdb_in_tag, cdb_in_data,
        input  issue_valid, issue_op, issue_src1_data, issue_src2_data,
        input  issue_src1_valid, issue_src2_valid,
        output issue_ready, issue_tag,
        output dispatch_valid, dispatch_op, dispatch_src1, dispatch_src2, dispatch_tag,
        input  dispatch_ready
    );

    // Issue stage / FU / CDB side.
    modport master (
        output cdb_in_valid, cdb_in_tag, cdb_in_data,
        output issue_valid, issue_op, issue_src1_data, issue_src2_data,
        output issue_src1_valid, issue_src2_valid,
        input  issue_ready, issue_tag,
        input  dispatch_valid, dispatch_op, dispatch_src1, dispatch_src2, dispatch_tag,
        output dispatch_ready
    );

endinterface : reservation_station_if
`default_nettype wire

// File: rtl/cdb_result_listener.sv
`default_nettype none
// ============================================================================
// Module      : cdb_result_listener
// Description : One operand slot: holds a value or a producer tag and captures
//               the CDB result when the tag matches.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_result_listener #(
    parameter int W             = 4,
    parameter int DATA_WIDTH    = 4,
    parameter int CDB_TAG_WIDTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_listen_en,
    input  wire logic                     i_load,
    input  wire logic                     i_load_valid,
    input  wire logic [W-1:0]             i_load_data,
    input  wire logic                     i_cdb_valid,
    input  wire logic [CDB_TAG_WIDTH-1:0] i_cdb_tag,
    input  wire logic [DATA_WIDTH-1:0]    i_cdb_data,
    output logic [W-1:0]                  o_data,
    output logic                          o_valid_nxt
);
    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_hit;

    // While invalid, the low bits of the stored word are the producer tag.
    assign w_hit = i_listen_en & ~r_valid & i_cdb_valid
                 & (r_data[CDB_TAG_WIDTH-1:0] == i_cdb_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= i_load_valid;
            r_data  <= i_load_data;
        end else if (w_hit) begin
            r_valid <= 1'b1;
            r_data  <= W'(i_cdb_data);
        end
    end

    assign o_data      = r_data;
    assign o_valid_nxt = r_valid | w_hit;

endmodule : cdb_result_listener
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station
// Description : Tomasulo reservation station feeding one functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int ENTRY_COUNT   = 4,
    parameter int DATA_WIDTH    = 4,
    parameter int CDB_TAG_WIDTH = 4,
    parameter int OP_WIDTH      = 2,
    parameter int TAG_BASE      = 0
) (
    input wire logic             clk,
    input wire logic             rst_n,
    reservation_station_if.slave rs
);
    localparam int W     = max_int(DATA_WIDTH, CDB_TAG_WIDTH);
    localparam int IDX_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
    localparam logic [CDB_TAG_WIDTH-1:0] c_tag_base = CDB_TAG_WIDTH'(TAG_BASE);

    logic [ENTRY_COUNT-1:0] w_free, w_ready, w_alloc, w_listen;
    logic [ENTRY_COUNT-1:0] w_src1_valid_nxt, w_src2_valid_nxt;
    logic [W-1:0]           w_src1_data [ENTRY_COUNT];
    logic [W-1:0]           w_src2_data [ENTRY_COUNT];
    logic [OP_WIDTH-1:0]    w_op        [ENTRY_COUNT];

    logic             w_free_any, w_ready_any;
    logic [IDX_W-1:0] w_free_idx, w_ready_idx;
    logic             w_issue_fire, w_dispatch_fire;
    logic             w_byp1, w_byp2, w_cmd1_valid, w_cmd2_valid;
    logic [W-1:0]     w_cmd1_data, w_cmd2_data, w_sel_src1, w_sel_src2;

    always_comb begin
        w_free_any  = 1'b0;
        w_free_idx  = '0;
        w_ready_any = 1'b0;
        w_ready_idx = '0;
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_ready_any = 1'b1;
                w_ready_idx = IDX_W'(i);
            end
        end
    end

    assign w_issue_fire    = rs.issue_valid & rs.issue_ready;
    assign w_dispatch_fire = w_ready_any & rs.dispatch_ready;

    // Same-cycle bypass: a missing operand whose producer is on the CDB now is
    // loaded as a value instead of a tag.
    assign w_byp1 = ~rs.issue_src1_valid & rs.cdb_in_valid
                  & (rs.issue_src1_data[CDB_TAG_WIDTH-1:0] == rs.cdb_in_tag);
    assign w_byp2 = ~rs.issue_src2_valid & rs.cdb_in_valid
                  & (rs.issue_src2_data[CDB_TAG_WIDTH-1:0] == rs.cdb_in_tag);
    assign w_cmd1_valid = rs.issue_src1_valid | w_byp1;
    assign w_cmd2_valid = rs.issue_src2_valid | w_byp2;
    assign w_cmd1_data  = w_byp1 ? W'(rs.cdb_in_data) : rs.issue_src1_data;
    assign w_cmd2_data  = w_byp2 ? W'(rs.cdb_in_data) : rs.issue_src2_data;

    generate
        for (genvar i = 0; i < ENTRY_COUNT; i++) begin : g_entry
            localparam logic [CDB_TAG_WIDTH-1:0] c_own_tag = CDB_TAG_WIDTH'(TAG_BASE + i);

            entry_state_e        r_state;
            logic [OP_WIDTH-1:0] r_op;

            assign w_free[i]   = (r_state == ST_FREE);
            assign w_ready[i]  = (r_state == ST_READY);
            assign w_listen[i] = (r_state != ST_FREE);
            assign w_alloc[i]  = w_issue_fire & (w_free_idx == IDX_W'(i));
            assign w_op[i]     = r_op;

            cdb_result_listener #(
                .W(W), .DATA_WIDTH(DATA_WIDTH), .CDB_TAG_WIDTH(CDB_TAG_WIDTH)
            ) u_src1 (
                .clk(clk), .rst_n(rst_n),
                .i_listen_en(w_listen[i]), .i_load(w_alloc[i]),
                .i_load_valid(w_cmd1_valid), .i_load_data(w_cmd1_data),
                .i_cdb_valid(rs.cdb_in_valid), .i_cdb_tag(rs.cdb_in_tag),
                .i_cdb_data(rs.cdb_in_data),
                .o_data(w_src1_data[i]), .o_valid_nxt(w_src1_valid_nxt[i])
            );

            cdb_result_listener #(
                .W(W), .DATA_WIDTH(DATA_WIDTH), .CDB_TAG_WIDTH(CDB_TAG_WIDTH)
            ) u_src2 (
                .clk(clk), .rst_n(rst_n),
                .i_listen_en(w_listen[i]), .i_load(w_alloc[i]),
                .i_load_valid(w_cmd2_valid), .i_load_data(w_cmd2_data),
                .i_cdb_valid(rs.cdb_in_valid), .i_cdb_tag(rs.cdb_in_tag),
                .i_cdb_data(rs.cdb_in_data),
                .o_data(w_src2_data[i]), .o_valid_nxt(w_src2_valid_nxt[i])
            );

            // Own-tag broadcasts outside EXECUTING are protocol errors and fall
            // through the case untouched.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_FREE;
                    r_op    <= '0;
                end else begin
                    case (r_state)
                        ST_FREE: begin
                            if (w_alloc[i]) begin
                                r_op    <= rs.issue_op;
                                r_state <= (w_cmd1_valid & w_cmd2_valid) ? ST_READY : ST_WAITING;
                            end
                        end
                        ST_WAITING: begin
                            if (w_src1_valid_nxt[i] & w_src2_valid_nxt[i])
                                r_state <= ST_READY;
                        end
                        ST_READY: begin
                            if (w_dispatch_fire && (w_ready_idx == IDX_W'(i)))
                                r_state <= ST_EXECUTING;
                        end
                        ST_EXECUTING: begin
                            if (rs.cdb_in_valid && (rs.cdb_in_tag == c_own_tag))
                                r_state <= ST_FREE;
                        end
                        default: r_state <= ST_FREE;
                    endcase
                end
            end
        end
    endgenerate

    assign w_sel_src1 = w_src1_data[w_ready_idx];
    assign w_sel_src2 = w_src2_data[w_ready_idx];

    assign rs.issue_ready    = rst_n & w_free_any;
    assign rs.issue_tag      = c_tag_base + CDB_TAG_WIDTH'(w_free_idx);
    assign rs.dispatch_valid = w_ready_any;
    assign rs.dispatch_op    = w_op[w_ready_idx];
    assign rs.dispatch_src1  = w_sel_src1[DATA_WIDTH-1:0];
    assign rs.dispatch_src2  = w_sel_src2[DATA_WIDTH-1:0];
    assign rs.dispatch_tag   = c_tag_base + CDB_TAG_WIDTH'(w_ready_idx);

endmodule : reservation_station
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_reservation_station
// Description : Directed self-checking bench for reservation_station.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reservation_station_if #(.DATA_WIDTH(4), .CDB_TAG_WIDTH(4), .OP_WIDTH(2)) rs_if ();

    reservation_station #(
        .ENTRY_COUNT(4), .DATA_WIDTH(4), .CDB_TAG_WIDTH(4), .OP_WIDTH(2), .TAG_BASE(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rs(rs_if)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_if.cdb_in_valid     = 1'b0;
        rs_if.cdb_in_tag       = '0;
        rs_if.cdb_in_data      = '0;
        rs_if.issue_valid      = 1'b0;
        rs_if.issue_op         = '0;
        rs_if.issue_src1_data  = '0;
        rs_if.issue_src2_data  = '0;
        rs_if.issue_src1_valid = 1'b0;
        rs_if.issue_src2_valid = 1'b0;
        rs_if.dispatch_ready   = 1'b0;
    endtask

    task automatic drive_issue(input logic [1:0] op, input logic [3:0] s1, input logic v1,
                               input logic [3:0] s2, input logic v2);
        rs_if.issue_valid      = 1'b1;
        rs_if.issue_op         = op;
        rs_if.issue_src1_data  = s1;
        rs_if.issue_src1_valid = v1;
        rs_if.issue_src2_data  = s2;
        rs_if.issue_src2_valid = v2;
    endtask

    task automatic drive_cdb(input logic [3:0] tag, input logic [3:0] data);
        rs_if.cdb_in_valid = 1'b1;
        rs_if.cdb_in_tag   = tag;
        rs_if.cdb_in_data  = data;
    endtask

    // Dispatches the offered entry 0 and completes it with a CDB broadcast.
    task automatic drain_entry0();
        rs_if.dispatch_ready = 1'b1;
        cycle();
        rs_if.dispatch_ready = 1'b0;
        drive_cdb(4'd0, 4'd0);
        cycle();
        rs_if.cdb_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (rs_if.issue_ready !== 1'b0) begin
            errors++; $display("FAIL reset_issue_ready got %0b exp 0", rs_if.issue_ready);
        end
        checks++;
        if (rs_if.dispatch_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dispatch_valid got %0b exp 0", rs_if.dispatch_valid);
        end
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (rs_if.issue_ready !== 1'b1) begin
            errors++; $display("FAIL release_issue_ready got %0b exp 1", rs_if.issue_ready);
        end
        checks++;
        if (rs_if.issue_tag !== 4'd0) begin
            errors++; $display("FAIL release_issue_tag got %0d exp 0", rs_if.issue_tag);
        end
    endtask

    task automatic test_single_issue();
        drive_issue(2'd1, 4'd3, 1'b1, 4'd5, 1'b1);
        cycle();
        rs_if.issue_valid = 1'b0;
        checks++;
        if (rs_if.dispatch_valid !== 1'b1) begin
            errors++; $display("FAIL single_dispatch_valid got %0b exp 1", rs_if.dispatch_valid);
        end
        checks++;
        if (rs_if.dispatch_op !== 2'd1 || rs_if.dispatch_tag !== 4'd0) begin
            errors++; $display("FAIL single_op_tag got op %0d tag %0d exp op 1 tag 0",
                               rs_if.dispatch_op, rs_if.dispatch_tag);
        end
        checks++;
        if (rs_if.dispatch_src1 !== 4'd3 || rs_if.dispatch_src2 !== 4'd5) begin
            errors++; $display("FAIL single_srcs got %0d/%0d exp 3/5",
                               rs_if.dispatch_src1, rs_if.dispatch_src2);
        end
        checks++;
        if (rs_if.issue_tag !== 4'd1) begin
            errors++; $display("FAIL single_next_tag got %0d exp 1", rs_if.issue_tag);
        end
        rs_if.dispatch_ready = 1'b1;
        cycle();
        rs_if.dispatch_ready = 1'b0;
        checks++;
        if (rs_if.dispatch_valid !== 1'b0) begin
            errors++; $display("FAIL single_executing got %0b exp 0", rs_if.dispatch_valid);
        end
        drive_cdb(4'd0, 4'd0);
        cycle();
        rs_if.cdb_in_valid = 1'b0;
        checks++;
        if (rs_if.issue_tag !== 4'd0) begin
            errors++; $display("FAIL single_freed_tag got %0d exp 0", rs_if.issue_tag);
        end
    endtask

    task automatic test_wakeup();
        drive_issue(2'd2, 4'd7, 1'b0, 4'd2, 1'b1);
        cycle();
        rs_if.issue_valid = 1'b0;
        checks++;
        if (rs_if.dispatch_valid !== 1'b0) begin
            errors++; $display("FAIL wakeup_waiting got %0b exp 0", rs_if.dispatch_valid);
        end
        drive_cdb(4'd7, 4'd9);
        cycle();
        rs_if.cdb_in_valid = 1'b0;
        checks++;
        if (rs_if.dispatch_valid !== 1'b1 || rs_if.dispatch_tag !== 4'd0) begin
            errors++; $display("FAIL wakeup_ready got valid %0b tag %0d exp 1/0",
                               rs_if.dispatch_valid, rs_if.dispatch_tag);
        end
        checks++;
        if (rs_if.dispatch_src1 !== 4'd9 || rs_if.dispatch_src2 !== 4'd2) begin
            errors++; $display("FAIL wakeup_srcs got %0d/%0d exp 9/2",
                               rs_if.dispatch_src1, rs_if.dispatch_src2);
        end
        drain_entry0();
    endtask

    task automatic test_bypass();
        drive_issue(2'd3, 4'd1, 1'b1, 4'd6, 1'b0);
        drive_cdb(4'd6, 4'd4);
        cycle();
        rs_if.issue_valid  = 1'b0;
        rs_if.cdb_in_valid = 1'b0;
        checks++;
        if (rs_if.dispatch_valid !== 1'b1 || rs_if.dispatch_op !== 2'd3) begin
            errors++; $display("FAIL bypass_ready got valid %0b op %0d exp 1/3",
                               rs_if.dispatch_valid, rs_if.dispatch_op);
        end
        checks++;
        if (rs_if.dispatch_src1 !== 4'd1 || rs_if.dispatch_src2 !== 4'd4) begin
            errors++; $display("FAIL bypass_srcs got %0d/%0d exp 1/4",
                               rs_if.dispatch_src1, rs_if.dispatch_src2);
        end
        drain_entry0();
    endtask

    task automatic test_full();
        rs_if.dispatch_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rs_if.issue_ready !== 1'b1 || rs_if.issue_tag !== 4'(i)) begin
                errors++; $display("FAIL full_alloc_%0d got ready %0b tag %0d exp 1/%0d",
                                   i, rs_if.issue_ready, rs_if.issue_tag, i);
            end
            drive_issue(2'(i), 4'(i + 4), 1'b1, 4'(i + 10), 1'b1);
            cycle();
        end
        rs_if.issue_valid = 1'b0;
        checks++;
        if (rs_if.issue_ready !== 1'b0) begin
            errors++; $display("FAIL full_issue_ready got %0b exp 0", rs_if.issue_ready);
        end
        rs_if.dispatch_ready = 1'b1;
        cycle();
        cycle();
        rs_if.dispatch_ready = 1'b0;
        checks++;
        if (rs_if.dispatch_tag !== 4'd2) begin
            errors++; $display("FAIL full_offer_after_two got %0d exp 2", rs_if.dispatch_tag);
        end
        // Issue attempt during the completion cycle must not allocate.
        drive_issue(2'd0, 4'd0, 1'b1, 4'd0, 1'b1);
        drive_cdb(4'd1, 4'd0);
        cycle();
        rs_if.issue_valid  = 1'b0;
        rs_if.cdb_in_valid = 1'b0;
        checks++;
        if (rs_if.issue_ready !== 1'b1 || rs_if.issue_tag !== 4'd1) begin
            errors++; $display("FAIL full_freed got ready %0b tag %0d exp 1/1",
                               rs_if.issue_ready, rs_if.issue_tag);
        end
    endtask

    task automatic test_stall_and_error();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rs_if.dispatch_valid !== 1'b1 || rs_if.dispatch_tag !== 4'd2 ||
                rs_if.dispatch_op !== 2'd2) begin
                errors++; $display("FAIL stall_%0d_ctrl got valid %0b tag %0d op %0d exp 1/2/2",
                                   k, rs_if.dispatch_valid, rs_if.dispatch_tag, rs_if.dispatch_op);
            end
            checks++;
            if (rs_if.dispatch_src1 !== 4'd6 || rs_if.dispatch_src2 !== 4'd12) begin
                errors++; $display("FAIL stall_%0d_srcs got %0d/%0d exp 6/12",
                                   k, rs_if.dispatch_src1, rs_if.dispatch_src2);
            end
            cycle();
        end
        drive_cdb(4'd2, 4'd15);
        cycle();
        rs_if.cdb_in_valid = 1'b0;
        checks++;
        if (rs_if.dispatch_valid !== 1'b1 || rs_if.dispatch_tag !== 4'd2 ||
            rs_if.dispatch_src1 !== 4'd6) begin
            errors++; $display("FAIL error_bcast got valid %0b tag %0d src1 %0d exp 1/2/6",
                               rs_if.dispatch_valid, rs_if.dispatch_tag, rs_if.dispatch_src1);
        end
        checks++;
        if (rs_if.issue_tag !== 4'd1) begin
            errors++; $display("FAIL error_bcast_free got %0d exp 1", rs_if.issue_tag);
        end
        rs_if.dispatch_ready = 1'b1;
        cycle();
        rs_if.dispatch_ready = 1'b0;
        checks++;
        if (rs_if.dispatch_tag !== 4'd3) begin
            errors++; $display("FAIL error_then_dispatch got %0d exp 3", rs_if.dispatch_tag);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rs_if.dispatch_valid !== 1'b0 || rs_if.issue_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got dv %0b ir %0b exp 0/0",
                               rs_if.dispatch_valid, rs_if.issue_ready);
        end
        cycle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (rs_if.issue_ready !== 1'b1 || rs_if.issue_tag !== 4'd0 ||
            rs_if.dispatch_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_release got ir %0b tag %0d dv %0b exp 1/0/0",
                               rs_if.issue_ready, rs_if.issue_tag, rs_if.dispatch_valid);
        end
    endtask

    task automatic test_back_to_back();
        rs_if.dispatch_ready = 1'b1;
        drive_issue(2'd1, 4'd2, 1'b1, 4'd3, 1'b1);
        cycle();
        checks++;
        if (rs_if.dispatch_valid !== 1'b1 || rs_if.dispatch_tag !== 4'd0 ||
            rs_if.dispatch_src1 !== 4'd2) begin
            errors++; $display("FAIL b2b_first got dv %0b tag %0d src1 %0d exp 1/0/2",
                               rs_if.dispatch_valid, rs_if.dispatch_tag, rs_if.dispatch_src1);
        end
        checks++;
        if (rs_if.issue_tag !== 4'd1) begin
            errors++; $display("FAIL b2b_issue_tag got %0d exp 1", rs_if.issue_tag);
        end
        drive_issue(2'd2, 4'd5, 1'b1, 4'd7, 1'b1);
        cycle();
        rs_if.issue_valid = 1'b0;
        checks++;
        if (rs_if.dispatch_valid !== 1'b1 || rs_if.dispatch_tag !== 4'd1 ||
            rs_if.dispatch_src1 !== 4'd5 || rs_if.dispatch_src2 !== 4'd7) begin
            errors++; $display("FAIL b2b_second got dv %0b tag %0d srcs %0d/%0d exp 1/1/5/7",
                               rs_if.dispatch_valid, rs_if.dispatch_tag,
                               rs_if.dispatch_src1, rs_if.dispatch_src2);
        end
        cycle();
        rs_if.dispatch_ready = 1'b0;
        checks++;
        if (rs_if.dispatch_valid !== 1'b0 || rs_if.issue_tag !== 4'd2) begin
            errors++; $display("FAIL b2b_drained got dv %0b tag %0d exp 0/2",
                               rs_if.dispatch_valid, rs_if.issue_tag);
        end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_stall_and_error();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout reached at %0t", $time);
        $fatal(1);
    end

endmodule : tb_reservation_station
`default_nettype wire
